// File: rtl/se_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Holds the FSM state enum and the {pc, instr} fetch-queue entry.
package se_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALTED
  } fetch_state_e;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } fq_entry_t;

  localparam int          INSTR_BYTES = 4;
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

endpackage

// File: rtl/se_fetch_if.sv
// Valid/ready bundle carrying a fetch-queue entry toward decode.
// The producer (fetch) uses master; the consumer (decode) uses slave.
interface se_fetch_if;
  import se_fetch_pkg::*;

  logic      valid;
  logic      ready;
  fq_entry_t data;

  modport master (
    output valid,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    output ready
  );

endinterface

// File: rtl/se_fetch_queue.sv
// Small FIFO of fetch entries with flush and a registered head.
// The head register keeps the last popped entry visible when empty.
module se_fetch_queue
  import se_fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_i,
  input  fq_entry_t  wdata_i,
  input  logic       flush_i,
  output logic       full_o,
  se_fetch_if.master deq
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fq_entry_t     mem_q [DEPTH];
  fq_entry_t     mem_d [DEPTH];
  logic [PW-1:0] rd_q, rd_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  fq_entry_t     head_q, head_d;
  logic          pop;

  assign deq.valid = (cnt_q != '0);
  assign deq.data  = head_q;
  assign full_o    = (cnt_q == CW'(DEPTH));
  assign pop       = deq.valid & deq.ready;

  always_comb begin
    mem_d  = mem_q;
    rd_d   = rd_q;
    wr_d   = wr_q;
    cnt_d  = cnt_q;
    head_d = head_q;
    if (flush_i) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_i) begin
        mem_d[wr_q] = wdata_i;
        wr_d        = wr_q + PW'(1);
      end
      if (pop) begin
        rd_d = rd_q + PW'(1);
      end
      unique case ({push_i, pop})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
      // mem_d already holds this cycle's write, covering push into empty
      if (cnt_d != '0) begin
        head_d = mem_d[rd_d];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q  <= '{default: '0};
      rd_q   <= '0;
      wr_q   <= '0;
      cnt_q  <= '0;
      head_q <= '0;
    end else begin
      mem_q  <= mem_d;
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      cnt_q  <= cnt_d;
      head_q <= head_d;
    end
  end

endmodule

// File: rtl/se_fetch_stage.sv
// Fetch stage: PC register, IDLE/RUN/HALTED FSM, redirect and queue control.
// Define SE_FETCH_MISALIGN_CHECK_EN to halt on a misaligned PC.
module se_fetch_stage
  import se_fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          FQ_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic [63:0] pc_o,
  input  logic [31:0] instr_i,
  input  logic        redirect_i,
  input  logic [63:0] redirect_pc_i,
  input  logic        halt_i,
  input  logic        resume_i,
  output logic        dec_valid_o,
  input  logic        dec_ready_i,
  output logic [31:0] dec_instr_o,
  output logic [63:0] dec_pc_o,
  output logic        halted_o,
  output logic        misalign_o
);

  fetch_state_e state_q, state_d;
  logic [63:0]  pc_q, pc_d;
  logic         run;
  logic         redir;
  logic         fault;
  logic         push;
  logic         full;
  fq_entry_t    wentry;

  se_fetch_if dq ();

  assign dq.ready    = dec_ready_i;
  assign dec_valid_o = dq.valid;
  assign dec_instr_o = dq.data.instr;
  assign dec_pc_o    = dq.data.pc;
  assign pc_o        = pc_q;
  assign halted_o    = (state_q == HALTED);

  assign run    = (state_q == RUN);
  assign redir  = redirect_i & (state_q != IDLE);
  assign wentry = '{pc: pc_q, instr: instr_i};

`ifdef SE_FETCH_MISALIGN_CHECK_EN
  logic misalign_q, misalign_d;

  assign fault      = run & ~redirect_i & (pc_q[1:0] != 2'b00);
  assign misalign_o = misalign_q;

  always_comb begin
    misalign_d = misalign_q;
    if (redir) begin
      misalign_d = 1'b0;
    end else if (fault) begin
      misalign_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end
`else
  assign fault      = 1'b0;
  assign misalign_o = 1'b0;
`endif

  // a pop frees a slot, so a full queue still accepts in the same cycle
  assign push = run & ~redirect_i & ~halt_i & ~fault
              & (~full | (dq.valid & dec_ready_i));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = RUN;
      RUN:     if (halt_i | fault) state_d = HALTED;
      HALTED:  if (resume_i & ~halt_i) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pc_d = pc_q;
    if (redir) begin
      pc_d = redirect_pc_i;
    end else if (push) begin
      pc_d = pc_q + 64'(INSTR_BYTES);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  se_fetch_queue #(
    .DEPTH (FQ_DEPTH)
  ) u_fq (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .wdata_i (wentry),
    .flush_i (redir),
    .full_o  (full),
    .deq     (dq.master)
  );

endmodule
